// File: rtl/nios2_debug_host_pkg.sv
// Shared types and constants for the Nios II debug-slave host driver.
package nios2_debug_host_pkg;

  localparam int SR_WIDTH_DEFAULT = 38;
  localparam int IR_WIDTH_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } host_state_e;

  // Virtual IR codes understood by the debug slave
  localparam logic [1:0] IR_OCIMEM   = 2'b00;
  localparam logic [1:0] IR_TRACEMEM = 2'b01;
  localparam logic [1:0] IR_BREAK    = 2'b10;
  localparam logic [1:0] IR_ENABLE   = 2'b11;

endpackage

// File: rtl/nios2_debug_host_tck_gen.sv
// tck divider: registered tck plus strobes flagging the clk edge on which tck rises or falls.
module nios2_debug_host_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic start,
  output logic tck,
  output logic rise_en,
  output logic fall_en
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TCK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             phase_end;

  assign phase_end = (div_cnt == '0);
  assign rise_en   = run && phase_end && !tck;
  assign fall_en   = run && phase_end && tck;

  // Every period begins with a full low phase, so an accept always restarts low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= DIV_LOAD;
      tck     <= 1'b0;
    end else if (start || !run) begin
      div_cnt <= DIV_LOAD;
      tck     <= 1'b0;
    end else if (phase_end) begin
      div_cnt <= DIV_LOAD;
      tck     <= ~tck;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/nios2_debug_slave_host.sv
// Host-side virtual-JTAG driver for the Nios II debug slave: plays one
// UIR/CDR/SDR/UDR/RTI sequence per command and returns the captured tdo word.
module nios2_debug_slave_host
  import nios2_debug_host_pkg::*;
#(
  parameter int SR_WIDTH = SR_WIDTH_DEFAULT,
  parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // UIR   | ir_in presented, one tck period
  // CDR   | slave captures, ir_out sampled on the tck rise
  // SDR   | SR_WIDTH tck periods: tdi out, tdo captured
  // UDR   | slave updates from its shift register
  // RTI   | one tck period of run-test-idle
  // RESP  | rsp_valid held until rsp_ready

  localparam int CNT_W = $clog2(SR_WIDTH) + 1;

  host_state_e         state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SR_WIDTH-1:0] shift_q, cap;
  logic [IR_WIDTH-1:0] ir_q, rsp_ir_q;
  logic                accept, run, rise_en, fall_en, last_bit;

  assign accept     = (state == ST_IDLE) && cmd_valid;
  assign run        = !(state inside {ST_IDLE, ST_RESP});
  assign last_bit   = (bit_cnt == '0);
  assign ir_in      = ir_q;
  assign rsp_data   = cap;
  assign rsp_ir_out = rsp_ir_q;

  nios2_debug_host_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .start   (accept),
    .tck     (tck),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // JTAG states advance only on a tck fall so outputs never move across a rise.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid)            state_nxt = ST_UIR;
      ST_UIR:  if (fall_en)              state_nxt = ST_CDR;
      ST_CDR:  if (fall_en)              state_nxt = ST_SDR;
      ST_SDR:  if (fall_en && last_bit)  state_nxt = ST_UDR;
      ST_UDR:  if (fall_en)              state_nxt = ST_RTI;
      ST_RTI:  if (fall_en)              state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)            state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    jtag_state_rti = 1'b0;
    tdi            = 1'b0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_UIR:  vs_uir    = 1'b1;
      ST_CDR:  vs_cdr    = 1'b1;
      ST_SDR: begin
        vs_sdr = 1'b1;
        tdi    = shift_q[0];
      end
      ST_UDR:  vs_udr         = 1'b1;
      ST_RTI:  jtag_state_rti = 1'b1;
      ST_RESP: rsp_valid      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      cap      <= '0;
      ir_q     <= '0;
      rsp_ir_q <= '0;
      bit_cnt  <= '0;
    end else if (accept) begin
      shift_q <= cmd_data;
      ir_q    <= cmd_ir;
      cap     <= '0;
    end else begin
      if (state == ST_CDR && rise_en) rsp_ir_q <= ir_out;
      if (state == ST_CDR && fall_en) bit_cnt  <= CNT_W'(SR_WIDTH - 1);
      if (state == ST_SDR && rise_en) cap      <= {tdo, cap[SR_WIDTH-1:1]};
      if (state == ST_SDR && fall_en) begin
        shift_q <= shift_q >> 1;
        bit_cnt <= bit_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nios2_debug_slave_host.sv
// Directed bench: two hosts (TCK_DIV 2 and 1), each driving a behavioural virtual-JTAG slave.
module tb_nios2_debug_slave_host;
  import nios2_debug_host_pkg::*;

  localparam int SRW = 38;
  localparam int IRW = 2;
  localparam logic [SRW-1:0] LOAD_B1 = 38'h01_2345_6789;
  localparam logic [SRW-1:0] LOAD_B2 = 38'h3C_3C3C_C3C3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // host A, TCK_DIV = 2
  logic           cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_ready_a;
  logic [IRW-1:0] cmd_ir_a, rsp_ir_out_a, ir_in_a, ir_out_a;
  logic [SRW-1:0] cmd_data_a, rsp_data_a;
  logic           tck_a, tdi_a, tdo_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a, rti_a;

  // host B, TCK_DIV = 1
  logic           cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
  logic [IRW-1:0] cmd_ir_b, rsp_ir_out_b, ir_in_b, ir_out_b;
  logic [SRW-1:0] cmd_data_b, rsp_data_b;
  logic           tck_b, tdi_b, tdo_b, vs_uir_b, vs_cdr_b, vs_sdr_b, vs_udr_b, rti_b;

  nios2_debug_slave_host #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(2)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_ir(cmd_ir_a), .cmd_data(cmd_data_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a), .rsp_ir_out(rsp_ir_out_a),
    .tck(tck_a), .tdi(tdi_a), .tdo(tdo_a), .ir_in(ir_in_a), .ir_out(ir_out_a),
    .vs_uir(vs_uir_a), .vs_cdr(vs_cdr_a), .vs_sdr(vs_sdr_a), .vs_udr(vs_udr_a), .jtag_state_rti(rti_a)
  );

  nios2_debug_slave_host #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_data(cmd_data_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_ir_out(rsp_ir_out_b),
    .tck(tck_b), .tdi(tdi_b), .tdo(tdo_b), .ir_in(ir_in_b), .ir_out(ir_out_b),
    .vs_uir(vs_uir_b), .vs_cdr(vs_cdr_b), .vs_sdr(vs_sdr_b), .vs_udr(vs_udr_b), .jtag_state_rti(rti_b)
  );

  // Behavioural slaves: capture in CDR, shift on tck rise in SDR, tdo = sr[0]
  logic [SRW-1:0] sr_a = '0, load_a = '0, udr_sr_a = '0;
  always @(posedge tck_a) begin
    if (vs_cdr_a)      sr_a <= load_a;
    else if (vs_sdr_a) sr_a <= {tdi_a, sr_a[SRW-1:1]};
    else if (vs_udr_a) udr_sr_a <= sr_a;
  end
  assign tdo_a = sr_a[0];

  logic [SRW-1:0] sr_b = '0;
  logic [SRW-1:0] udr_q_b[$];
  always @(posedge tck_b) begin
    if (vs_cdr_b)      sr_b <= (ir_in_b == IR_TRACEMEM) ? LOAD_B1 : LOAD_B2;
    else if (vs_sdr_b) sr_b <= {tdi_b, sr_b[SRW-1:1]};
    else if (vs_udr_b) udr_q_b.push_back(sr_b);
  end
  assign tdo_b = sr_b[0];

  // Monitors on host A
  int sdr_hi_a = 0, udr_hi_a = 0, rises_a = 0, rises_b = 0, viol_a = 0;
  logic [IRW-1:0] uir_ir_a = '0;
  logic [IRW+5:0] so_a, so_prev_a = '0;
  assign so_a = {tdi_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a, rti_a, ir_in_a};
  always @(negedge clk) begin
    if (vs_sdr_a) sdr_hi_a <= sdr_hi_a + 1;
    if (vs_udr_a) udr_hi_a <= udr_hi_a + 1;
    if (vs_uir_a) uir_ir_a <= ir_in_a;
    so_prev_a <= so_a;
  end
  always @(posedge tck_a) begin
    rises_a = rises_a + 1;
    #1;
    if (so_a !== so_prev_a) viol_a = viol_a + 1;
  end
  always @(posedge tck_b) rises_b <= rises_b + 1;

  task automatic run_cmd_a(input logic [IRW-1:0] ir, input logic [SRW-1:0] data, output int lat);
    int acc;
    lat = -1;
    @(negedge clk);
    cmd_valid_a = 1'b1; cmd_ir_a = ir; cmd_data_a = data;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid_a = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid_a) begin
        lat = cyc - acc;
        break;
      end
    end
  endtask

  task automatic finish_rsp_a();
    @(negedge clk); rsp_ready_a = 1'b1;
    @(negedge clk); rsp_ready_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({tck_a, tdi_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a, rti_a, rsp_valid_a} !== 8'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000000", {tck_a, tdi_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a, rti_a, rsp_valid_a});
    end
    checks++;
    if (cmd_ready_a !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_a); end
    checks++;
    if ({ir_in_a, rsp_ir_out_a, rsp_data_a} !== '0) begin
      errors++; $display("FAIL reset_data: ir_in %h rsp_ir_out %h rsp_data %h, want all 0", ir_in_a, rsp_ir_out_a, rsp_data_a);
    end
    checks++;
    if ({cmd_ready_b, tck_b, rsp_valid_b} !== 3'b100) begin
      errors++; $display("FAIL reset_b: got %b want 100", {cmd_ready_b, tck_b, rsp_valid_b});
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_transfer();
    int lat, s0, r0, v0;
    ir_out_a = IR_BREAK;
    load_a   = 38'h2A_5A5A_5A5A;
    s0 = sdr_hi_a; r0 = rises_a; v0 = viol_a;
    run_cmd_a(IR_OCIMEM, 38'h15_A5A5_A5A5, lat);
    checks++;
    if (lat !== 168) begin errors++; $display("FAIL rsp_latency: got %0d want 168", lat); end
    checks++;
    if (rsp_data_a !== 38'h2A_5A5A_5A5A) begin errors++; $display("FAIL rsp_data: got %h want 2a5a5a5a5a", rsp_data_a); end
    checks++;
    if (udr_sr_a !== 38'h15_A5A5_A5A5) begin errors++; $display("FAIL slave_sr: got %h want 15a5a5a5a5", udr_sr_a); end
    checks++;
    if (rsp_ir_out_a !== 2'b10) begin errors++; $display("FAIL rsp_ir_out: got %b want 10", rsp_ir_out_a); end
    checks++;
    if (sdr_hi_a - s0 !== 152) begin errors++; $display("FAIL vs_sdr_len: got %0d want 152", sdr_hi_a - s0); end
    checks++;
    if (rises_a - r0 !== 42) begin errors++; $display("FAIL tck_rises: got %0d want 42", rises_a - r0); end
    checks++;
    if (viol_a - v0 !== 0) begin errors++; $display("FAIL tck_rise_stable: got %0d changes want 0", viol_a - v0); end
  endtask

  // Continues from the RESP state left by test_transfer
  task automatic test_rsp_hold();
    cmd_valid_a = 1'b1; cmd_ir_a = IR_BREAK; cmd_data_a = 38'h3F_0000_FFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid_a, cmd_ready_a, vs_uir_a, rsp_data_a} !== {3'b100, 38'h2A_5A5A_5A5A}) begin
        errors++; $display("FAIL rsp_hold[%0d]: valid %b ready %b uir %b data %h", i, rsp_valid_a, cmd_ready_a, vs_uir_a, rsp_data_a);
      end
    end
    cmd_valid_a = 1'b0; rsp_ready_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready_a, rsp_valid_a} !== 2'b10) begin
      errors++; $display("FAIL rsp_release: ready %b valid %b want 1 0", cmd_ready_a, rsp_valid_a);
    end
    rsp_ready_a = 1'b0;
    @(negedge clk);
    checks++;
    if (ir_in_a !== IR_OCIMEM) begin errors++; $display("FAIL ignored_cmd: ir_in got %b want 00", ir_in_a); end
  endtask

  task automatic test_ir_in();
    int lat;
    ir_out_a = IR_TRACEMEM;
    load_a   = 38'h00_0000_0001;
    run_cmd_a(IR_ENABLE, 38'h3F_FFFF_FFFE, lat);
    checks++;
    if (uir_ir_a !== 2'b11) begin errors++; $display("FAIL ir_in_uir: got %b want 11", uir_ir_a); end
    checks++;
    if ({rsp_data_a, rsp_ir_out_a} !== {38'h00_0000_0001, 2'b01}) begin
      errors++; $display("FAIL ir_cmd_rsp: data %h ir_out %b want 0000000001 01", rsp_data_a, rsp_ir_out_a);
    end
    checks++;
    if (udr_sr_a !== 38'h3F_FFFF_FFFE) begin errors++; $display("FAIL ir_cmd_slave: got %h want 3ffffffffe", udr_sr_a); end
    finish_rsp_a();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready_a, ir_in_a} !== 3'b111) begin
      errors++; $display("FAIL ir_in_idle: ready %b ir_in %b want 1 11", cmd_ready_a, ir_in_a);
    end
  endtask

  task automatic test_reset_mid();
    int lat, u0;
    logic found;
    found = 1'b0;
    load_a = 38'h2A_5A5A_5A5A;
    @(negedge clk); cmd_valid_a = 1'b1; cmd_ir_a = IR_BREAK; cmd_data_a = 38'h15_A5A5_A5A5;
    @(negedge clk); cmd_valid_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (vs_sdr_a) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL reach_sdr: got %b want 1", found); end
    repeat (68) @(negedge clk);
    u0 = udr_hi_a;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({tck_a, tdi_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a, rti_a, rsp_valid_a} !== 8'b0) begin
      errors++; $display("FAIL midreset_ctrl: got %b want 00000000", {tck_a, tdi_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a, rti_a, rsp_valid_a});
    end
    checks++;
    if ({cmd_ready_a, ir_in_a, rsp_ir_out_a, rsp_data_a} !== {1'b1, 42'b0}) begin
      errors++; $display("FAIL midreset_data: ready %b ir_in %b ir_out %b data %h", cmd_ready_a, ir_in_a, rsp_ir_out_a, rsp_data_a);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (udr_hi_a - u0 !== 0) begin errors++; $display("FAIL midreset_no_udr: got %0d udr cycles want 0", udr_hi_a - u0); end
    load_a = 38'h12_3456_789A;
    run_cmd_a(IR_TRACEMEM, 38'h0F_EDCB_A987, lat);
    checks++;
    if (lat !== 168) begin errors++; $display("FAIL post_reset_latency: got %0d want 168", lat); end
    checks++;
    if ({rsp_data_a, udr_sr_a} !== {38'h12_3456_789A, 38'h0F_EDCB_A987}) begin
      errors++; $display("FAIL post_reset_xfer: rsp %h slave %h want 123456789a 0fedcba987", rsp_data_a, udr_sr_a);
    end
    finish_rsp_a();
  endtask

  task automatic test_back_to_back();
    int k, idle, acc, r0;
    int tr[2];
    logic [SRW-1:0] rsp[2];
    k = 0; idle = 0; tr[0] = 0; tr[1] = 0; rsp[0] = '0; rsp[1] = '0;
    ir_out_b = IR_TRACEMEM;
    rsp_ready_b = 1'b1;
    r0 = rises_b;
    @(negedge clk);
    cmd_valid_b = 1'b1; cmd_ir_b = IR_TRACEMEM; cmd_data_b = 38'h2B_BBBB_0000;
    @(posedge clk); #1;
    acc = cyc;
    cmd_ir_b = IR_BREAK; cmd_data_b = 38'h05_5555_AAAA;
    for (int i = 0; i < 400 && k < 2; i++) begin
      @(negedge clk);
      if (rsp_valid_b) begin
        rsp[k] = rsp_data_b; tr[k] = cyc; k++;
      end else if (k == 1 && cmd_ready_b) begin
        idle++;
      end else if (k == 1 && idle > 0) begin
        cmd_valid_b = 1'b0;
      end
    end
    cmd_valid_b = 1'b0;
    @(negedge clk); rsp_ready_b = 1'b0;
    checks++;
    if (k !== 2) begin errors++; $display("FAIL b2b_count: got %0d responses want 2", k); end
    checks++;
    if (rsp[0] !== LOAD_B1) begin errors++; $display("FAIL b2b_rsp0: got %h want %h", rsp[0], LOAD_B1); end
    checks++;
    if (rsp[1] !== LOAD_B2) begin errors++; $display("FAIL b2b_rsp1: got %h want %h", rsp[1], LOAD_B2); end
    checks++;
    if (idle !== 1) begin errors++; $display("FAIL b2b_idle: got %0d idle cycles want 1", idle); end
    checks++;
    if (tr[0] - acc !== 84) begin errors++; $display("FAIL b2b_latency: got %0d want 84", tr[0] - acc); end
    checks++;
    if (tr[1] - tr[0] !== 86) begin errors++; $display("FAIL b2b_gap: got %0d want 86", tr[1] - tr[0]); end
    checks++;
    if (rises_b - r0 !== 84) begin errors++; $display("FAIL b2b_tck_rises: got %0d want 84", rises_b - r0); end
    checks++;
    if (udr_q_b.size() != 2) begin
      errors++; $display("FAIL b2b_slave_updates: got %0d want 2", udr_q_b.size());
    end else if (udr_q_b[0] !== 38'h2B_BBBB_0000 || udr_q_b[1] !== 38'h05_5555_AAAA) begin
      errors++; $display("FAIL b2b_slave_sr: got %h %h want 2bbbbb0000 055555aaaa", udr_q_b[0], udr_q_b[1]);
    end
    checks++;
    if (rsp_ir_out_b !== 2'b01) begin errors++; $display("FAIL b2b_ir_out: got %b want 01", rsp_ir_out_b); end
  endtask

  initial begin
    cmd_valid_a = 1'b0; cmd_ir_a = '0; cmd_data_a = '0; rsp_ready_a = 1'b0; ir_out_a = '0;
    cmd_valid_b = 1'b0; cmd_ir_b = '0; cmd_data_b = '0; rsp_ready_b = 1'b0; ir_out_b = '0;
    test_reset();
    test_transfer();
    test_rsp_hold();
    test_ir_in();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
